// File: rtl/cnt_ctrl_arbiter_if.sv
// cnt_ctrl_arbiter_if: raw board keys in, BCD count, mode and grant pulses out
interface cnt_ctrl_arbiter_if;
  logic       key_clr;
  logic       key_up;
  logic       key_dn;
  logic       key_mode;
  logic [7:0] cnt_out;
  logic [1:0] mode_out;
  logic [3:0] grant;
  modport master (output key_clr, key_up, key_dn, key_mode, input cnt_out, mode_out, grant);
  modport slave  (input key_clr, key_up, key_dn, key_mode, output cnt_out, mode_out, grant);
endinterface

// File: rtl/cnt_ctrl_arbiter.sv
// cnt_ctrl_arbiter: mode-gated fixed-priority arbiter (clr>up>dn>tick) owning a 00..99 BCD counter.
// Define KEY_DEBOUNCE_EN to filter every synchronised key through a DB_CYCLES stability window.
module cnt_ctrl_arbiter #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 1000000
) (
  input logic clk,
  input logic rst,
  cnt_ctrl_arbiter_if.slave bus
);
  typedef enum logic [1:0] {MANUAL = 2'b00, AUTO = 2'b01, HOLD = 2'b10} mode_e;
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, level, req;
  logic [3:0] grant_q, grant_d;
  logic [7:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic tick;
  mode_e mode_q, mode_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] != 4'd9 ? {v[7:4], v[3:0] + 4'd1} : v[7:4] != 4'd9 ? {v[7:4] + 4'd1, 4'd0} : 8'h00;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return v[3:0] != 4'd0 ? {v[7:4], v[3:0] - 4'd1} : v[7:4] != 4'd0 ? {v[7:4] - 4'd1, 4'd9} : 8'h99;
  endfunction

  // key vector order: [3] clr, [2] up, [1] dn, [0] mode
  always_comb begin
    sync1_d = {bus.key_clr, bus.key_up, bus.key_dn, bus.key_mode};
    sync2_d = sync1_q;
    prev_d  = level;
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
  logic [CW-1:0] db_q [4];
  logic [CW-1:0] db_d [4];
  logic [3:0] stable_q, stable_d;

  always_comb begin
    stable_d = stable_q;
    for (int j = 0; j < 4; j++) begin
      db_d[j] = '0;
      if (sync2_q[j] != stable_q[j]) begin
        if (db_q[j] == DB_MAX) stable_d[j] = sync2_q[j];
        else db_d[j] = db_q[j] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int j = 0; j < 4; j++) db_q[j] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int j = 0; j < 4; j++) db_q[j] <= db_d[j];
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  assign req  = level & ~prev_q;
  assign tick = (mode_q == AUTO) && (div_q == DIV_MAX);

  // eligibility is judged on the current mode, so a coincident mode press never masks its partner
  always_comb begin
    grant_d = req[3]                      ? 4'b1000 :
              (req[2] && mode_q == MANUAL) ? 4'b0100 :
              (req[1] && mode_q == MANUAL) ? 4'b0010 :
              tick                         ? 4'b0001 : 4'b0000;
    cnt_d   = grant_d[3]                ? 8'h00 :
              (grant_d[2] | grant_d[0]) ? bcd_inc(cnt_q) :
              grant_d[1]                ? bcd_dec(cnt_q) : cnt_q;
    div_d   = (mode_q != AUTO || grant_d[3] || tick) ? '0 : div_q + 1'b1;
    mode_d  = mode_q == MANUAL ? (req[0] ? AUTO : MANUAL) :
              mode_q == AUTO   ? (req[0] ? HOLD : AUTO) :
              mode_q == HOLD   ? (req[0] ? MANUAL : HOLD) : MANUAL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      mode_q  <= MANUAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.cnt_out  = cnt_q;
  assign bus.mode_out = mode_q;
  assign bus.grant    = grant_q;
endmodule

// File: doc/cnt_ctrl_arbiter.md
Name: cnt_ctrl_arbiter

Overview:
Controller and owner of the two-digit BCD display counter (tens on DK5, ones on DK4, 00..99). It arbitrates four count requesters onto the single counter register: clear key, up key (S3), down key (S4) and an internal auto-tick. A mode state machine, stepped by the mode key, decides which requesters are eligible. It sits between the raw board keys and the seven-segment display driver.

Parameters:
TICK_DIV, 50000000, clk cycles per auto-tick (1 Hz at 50 MHz); must be >= 2.
DB_CYCLES, 1000000, debounce stability window in clk cycles (20 ms at 50 MHz); used only with KEY_DEBOUNCE_EN.

Ports:
clk  input  1  50 MHz system clock
rst  input  1  reset; synchronous, active-high, sampled on rising clk
key_clr  input  1  raw clear key, active-high, asynchronous to clk
key_up  input  1  raw S3 up key, active-high, asynchronous
key_dn  input  1  raw S4 down key, active-high, asynchronous
key_mode  input  1  raw mode key, active-high, asynchronous
cnt_out  output  8  BCD count; [7:4] tens (DK5), [3:0] ones (DK4)
mode_out  output  2  current mode: 00 MANUAL, 01 AUTO, 10 HOLD
grant  output  4  one-cycle one-hot grant pulse: [3] clr, [2] up, [1] dn, [0] tick

Behaviour:
- Reset, while rst=1 at a rising edge:
  - cnt_out=8'h00, mode_out=MANUAL, grant=0.
  - Tick divider=0; all synchroniser and edge registers=0.
- Key front end, per key:
  - Two-flop synchroniser, then a previous-value register.
  - Request = synced & ~prev, a single-cycle rise pulse.
  - No debounce in the default build.
  - Latency: a key high at sampling edge k updates cnt_out/grant/mode at edge k+2.
- Mode FSM, advanced by a key_mode rise pulse:
  - MANUAL -> AUTO -> HOLD -> MANUAL.
  - Code 11 is unreachable; if it occurs, go to MANUAL on the next edge.
  - Request eligibility is evaluated against the current mode, not the next one. A mode press coincident with an up press in MANUAL applies the up, then the mode changes.
- Eligibility:
  - MANUAL: clr, up, dn.
  - AUTO: clr, tick.
  - HOLD: clr only.
  - Ineligible requests are dropped, never queued.
- Fixed priority among eligible requests in the same cycle: clr > up > dn > tick.
  - Exactly one operation per cycle; losers are dropped.
  - grant asserts the winner's bit for exactly one cycle, coincident with the cnt_out update edge.
  - grant=0 when there is no winner.
- Operations:
  - clr: cnt_out := 00.
  - up/tick: BCD increment. Ones 9 -> 0 with carry into tens; 99 -> 00.
  - dn: BCD decrement. Ones 0 -> 9 with borrow from tens; 00 -> 99.
  - Non-BCD nibbles are unreachable and need no defined handling.
- Tick divider:
  - Counts 0..TICK_DIV-1 only while mode=AUTO; tick request is asserted in the cycle the counter = TICK_DIV-1, then the counter wraps to 0.
  - Held at 0 in MANUAL and HOLD.
  - Cleared to 0 on entry to AUTO and on any granted clr.
  - First tick arrives TICK_DIV cycles after AUTO entry.
- Reset mid-operation:
  - Synchronous rst overrides everything in that cycle, including a pending grant or a mode press.
  - A key held through rst deassertion is treated as a new rise two edges later, since the sync registers restart from 0.
- cnt_out holds its value whenever there is no grant.

Optional Feature:
KEY_DEBOUNCE_EN
- Defined:
  - Each synchronised key feeds a per-key counter and stable-level register.
  - The stable level flips only after the synced input differs from it for DB_CYCLES consecutive cycles; any agreeing sample resets the counter.
  - The rise pulse is taken from the stable level, adding DB_CYCLES cycles of latency.
  - Glitches shorter than DB_CYCLES are ignored.
  - Counters reset to 0 on rst.
- Undefined: no counters exist; the rise pulse comes directly from the synchroniser output, as described above.

Test Plan:
1. Reset, then 12 key_up pulses in MANUAL (each 4 cycles high, 4 low) -> cnt_out=8'h12; each press gives one grant=4'b0100 pulse, 2 edges after the key rises.
2. cnt_out=8'h99, key_up pulse -> 8'h00; then key_dn pulse -> 8'h99; cnt_out=8'h10, key_dn -> 8'h09.
3. key_clr, key_up and key_dn rise in the same cycle at cnt_out=8'h37 -> cnt_out=8'h00, grant=4'b1000 only; the up/dn are lost (no later change).
4. TICK_DIV=4, one key_mode press -> mode_out=01; cnt_out increments every 4 cycles, first increment 4 cycles after entry. key_up pulses in AUTO have no effect; a second key_mode gives mode_out=10 and freezes cnt_out; a key_clr in HOLD still gives 8'h00.
5. rst asserted in the same cycle as a key_up grant would occur (cnt_out=8'h05) -> next cycle cnt_out=8'h00, grant=0, mode_out=00.
6. KEY_DEBOUNCE_EN, DB_CYCLES=8: key_up 5-cycle glitch -> no change; key_up held 20 cycles -> one increment, grant 8+2 edges after the rise.
